ex_stage_sequencer: RTL and testbench
=====================================

# ex_stage_sequencer

Controls the execute stage of the pipelined core. It accepts one instruction at a time from decode over a valid/ready handshake and drives the executor's enable input. It holds that enable for single-cycle ALU operations or for a fixed multi-cycle multiply/divide latency, registers the result toward memory, and turns taken jumps into a one-cycle fetch redirect pulse. It also keeps retired-instruction and stall counters.

## Interface
- MULDIV_LATENCY, 8, cycles the execute enable is held for multiply/divide ops; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  sequencer can accept an instruction.
- id_pc  in  64  PC of the offered instruction.
- id_is_muldiv  in  1  offered instruction is a multi-cycle multiply/divide op.
- ex_enable  out  1  enable to the executor.
- ex_done  in  1  executor output valid.
- ex_jump  in  1  executor jump/branch-taken flag.
- ex_target  in  64  executor jump target.
- ex_result  in  64  executor ALU result.
- mem_valid  out  1  registered result available to the memory stage.
- mem_ready  in  1  memory stage accepts the result.
- mem_result  out  64  registered result.
- mem_pc  out  64  PC of the registered result.
- redirect_valid  out  1  one-cycle pulse: fetch must redirect and decode must flush.
- redirect_pc  out  64  redirect target.
- misalign_fault  out  1  one-cycle pulse: the jump target is misaligned.
- instr_count  out  32  number of instructions retired to the memory stage.
- stall_cycles  out  32  number of stall cycles.

## Operation
- States are IDLE, EXEC and OUT. Reset enters IDLE.
- **IDLE**
  - id_ready=1, except that it is 0 while reset is low and 0 in any cycle where redirect_valid=1.
  - On the handshake (id_valid & id_ready), latch id_pc. Load cnt with MULDIV_LATENCY-1 if id_is_muldiv, otherwise 0. Go to EXEC.
- **EXEC**
  - ex_enable=1.
  - If cnt≠0, decrement cnt.
  - If cnt==0 and ex_done=1:
    - capture ex_result into mem_result and the latched PC into mem_pc;
    - evaluate the jump (rules below);
    - go to OUT.
  - If cnt==0 and ex_done=0, stay in EXEC. Each such cycle counts as a stall.
  - ex_done is ignored while cnt≠0.
- **OUT**
  - mem_valid=1; mem_result and mem_pc are held stable.
  - If mem_ready=1: increment instr_count and go to IDLE.
  - If mem_ready=0: stay in OUT, hold data, and count a stall.
- **Jump evaluation** (on the EXEC→OUT transition, only if ex_jump=1)
  - Compute t = ex_target with bit 0 forced to 0.
  - If t[1]=0, assert redirect_valid=1 with redirect_pc=t for exactly the first OUT cycle.
  - If t[1]=1, assert misalign_fault=1 for exactly the first OUT cycle; no redirect is issued.
  - The result is still passed to the memory stage in both cases.
- **Counters**
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - stall_cycles increments by 1 for each EXEC cycle beyond the first, and for each OUT cycle with mem_ready=0.
- **Reset mid-operation:** any state is immediately returned to IDLE and everything is cleared. The in-flight instruction is discarded with no redirect and no mem_valid.

## Timing
- Reset values: every output is 0, including id_ready while reset is low. cnt=0; counters=0.
- ALU op, handshake in cycle 0:
  - ex_enable=1 in cycle 1;
  - mem_valid=1 from cycle 2;
  - any redirect_valid or misalign_fault pulse occurs in cycle 2 only;
  - if mem_ready=1 in cycle 2, IDLE (id_ready=1) in cycle 3.
- Muldiv op: ex_enable is held for cycles 1..MULDIV_LATENCY, and mem_valid rises in cycle MULDIV_LATENCY+1. MULDIV_LATENCY=1 behaves identically to an ALU op.
- Throughput: at most one instruction every 3 cycles. There is no bypass from OUT to EXEC.
- id_ready is a function of state only (registered). There is no combinational path from id_valid or mem_ready to id_ready.
- redirect_pc holds its value after the pulse until the next redirect.

## Test plan
- **Reset:** drive reset low for 3 cycles with id_valid=1 → every output is 0 and id_ready=0. Release reset → id_ready=1 in the next cycle; counters read 0.
- **ALU op:** id_pc=0x1000, ex_result=0x2A, ex_done=1, ex_jump=0 → cycle 2 shows mem_valid=1, mem_result=0x2A, mem_pc=0x1000, and no redirect. After mem_ready: instr_count=1, stall_cycles=0.
- **Taken branch:**
  - ex_jump=1, ex_target=0x1040 → redirect_valid=1 with redirect_pc=0x1040 for exactly one cycle, and id_ready=0 in that cycle.
  - ex_target=0x2001 → redirect_pc=0x2000.
- **Misaligned jump:** ex_target=0x2003 → misalign_fault pulses for one cycle; redirect_valid stays 0; mem_valid=1 as normal.
- **Muldiv:** MULDIV_LATENCY=8, id_is_muldiv=1, ex_done=1 throughout → ex_enable high for exactly 8 cycles; mem_valid rises in cycle 9; stall_cycles=7.
- **Backpressure and reset:**
  - Hold mem_ready=0 for 3 OUT cycles → mem_result and mem_pc are stable, id_ready=0, and stall_cycles increases by 3.
  - Assert reset in the middle of a muldiv EXEC → the block is in IDLE after reset release, mem_valid=0, and no redirect occurs.

Source files
------------

// File: rtl/ex_stage_sequencer.sv
// Execute-stage sequencer: accepts one decoded instruction, holds the executor
// enable for ALU or multi-cycle muldiv latency, registers the result toward memory.
module ex_stage_sequencer #(
    parameter int unsigned MULDIV_LATENCY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [63:0] id_pc,
    input  logic        id_is_muldiv,
    output logic        ex_enable,
    input  logic        ex_done,
    input  logic        ex_jump,
    input  logic [63:0] ex_target,
    input  logic [63:0] ex_result,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_result,
    output logic [63:0] mem_pc,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        misalign_fault,
    output logic [31:0] instr_count,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CTR_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   mem_result_q, mem_result_d;
    logic [XLEN-1:0]   mem_pc_q, mem_pc_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              misalign_q, misalign_d;
    logic              id_ready_q, id_ready_d;
    logic              ex_enable_q, ex_enable_d;
    logic              mem_valid_q, mem_valid_d;
    logic [CTR_W-1:0]  instr_q, instr_d;
    logic [CTR_W-1:0]  stall_q, stall_d;
    logic [XLEN-1:0]   jump_tgt_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pc_d             = pc_q;
        mem_result_d     = mem_result_q;
        mem_pc_d         = mem_pc_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        misalign_d       = 1'b0;
        instr_d          = instr_q;
        stall_d          = stall_q;
        jump_tgt_c       = ex_target & ~XLEN'(1);

        case (state_q)
            IDLE: begin
                if (id_valid && id_ready_q) begin
                    pc_d    = id_pc;
                    cnt_d   = id_is_muldiv ? CNT_W'(MULDIV_LATENCY - 1) : '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Every EXEC cycle except the completing one is a stall
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_d = stall_q + CTR_W'(1);
                end else if (ex_done) begin
                    mem_result_d = ex_result;
                    mem_pc_d     = pc_q;
                    state_d      = OUT;
                    if (ex_jump) begin
                        if (!jump_tgt_c[1]) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = jump_tgt_c;
                        end else begin
                            misalign_d = 1'b1;
                        end
                    end
                end else begin
                    stall_d = stall_q + CTR_W'(1);
                end
            end
            OUT: begin
                if (mem_ready) begin
                    instr_d = instr_q + CTR_W'(1);
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + CTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        id_ready_d  = (state_d == IDLE) && !redirect_valid_d;
        ex_enable_d = (state_d == EXEC);
        mem_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            pc_q             <= '0;
            mem_result_q     <= '0;
            mem_pc_q         <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            misalign_q       <= 1'b0;
            id_ready_q       <= 1'b0;
            ex_enable_q      <= 1'b0;
            mem_valid_q      <= 1'b0;
            instr_q          <= '0;
            stall_q          <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pc_q             <= pc_d;
            mem_result_q     <= mem_result_d;
            mem_pc_q         <= mem_pc_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            misalign_q       <= misalign_d;
            id_ready_q       <= id_ready_d;
            ex_enable_q      <= ex_enable_d;
            mem_valid_q      <= mem_valid_d;
            instr_q          <= instr_d;
            stall_q          <= stall_d;
        end
    end

    assign id_ready       = id_ready_q;
    assign ex_enable      = ex_enable_q;
    assign mem_valid      = mem_valid_q;
    assign mem_result     = mem_result_q;
    assign mem_pc         = mem_pc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign_fault = misalign_q;
    assign instr_count    = instr_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Bench for ex_stage_sequencer: directed plan items plus random instructions
// checked against a per-instruction timeline model.
module tb_ex_stage_sequencer;

    localparam int unsigned L = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic        id_is_muldiv;
    logic        ex_enable;
    logic        ex_done;
    logic        ex_jump;
    logic [63:0] ex_target;
    logic [63:0] ex_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_result;
    logic [63:0] mem_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        misalign_fault;
    logic [31:0] instr_count;
    logic [31:0] stall_cycles;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_instr;
    logic [31:0] exp_stall;
    logic [63:0] exp_rpc;

    ex_stage_sequencer #(.MULDIV_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_is_muldiv(id_is_muldiv),
        .ex_enable(ex_enable), .ex_done(ex_done), .ex_jump(ex_jump),
        .ex_target(ex_target), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result), .mem_pc(mem_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_fault(misalign_fault),
        .instr_count(instr_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, id_ready, 0);
        check({tag, "_en"}, ex_enable, 0);
        check({tag, "_mv"}, mem_valid, 0);
        check({tag, "_mres"}, mem_result, 0);
        check({tag, "_mpc"}, mem_pc, 0);
        check({tag, "_rv"}, redirect_valid, 0);
        check({tag, "_rpc"}, redirect_pc, 0);
        check({tag, "_mis"}, misalign_fault, 0);
        check({tag, "_ic"}, instr_count, 0);
        check({tag, "_sc"}, stall_cycles, 0);
    endtask

    task automatic idle_cycle();
        id_valid  = 1'b0;
        ex_done   = 1'($urandom);
        mem_ready = 1'($urandom);
        step();
        check("idle_rdy", id_ready, 1);
        check("idle_en", ex_enable, 0);
        check("idle_mv", mem_valid, 0);
    endtask

    // One instruction: enable for E = base latency + extra not-done cycles,
    // result visible for 1 + bp cycles, stalls add E-1+bp.
    task automatic run_instr(input bit md, input int dwait, input int bp, input bit jmp,
                             input logic [63:0] tgt, input logic [63:0] res,
                             input logic [63:0] pc);
        int          base;
        int          e;
        logic [63:0] t;
        bit          redir;
        bit          mis;
        base  = md ? int'(L) : 1;
        e     = base + dwait;
        t     = tgt & ~64'd1;
        redir = jmp && (t[1] == 1'b0);
        mis   = jmp && (t[1] == 1'b1);

        check("hs_rdy", id_ready, 1);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_is_muldiv = md;
        ex_done      = 1'($urandom);
        mem_ready    = 1'($urandom);
        step();
        for (int c = 1; c <= e; c++) begin
            check("ex_en", ex_enable, 1);
            check("ex_rdy", id_ready, 0);
            check("ex_mv", mem_valid, 0);
            check("ex_rv", redirect_valid, 0);
            id_valid     = 1'($urandom);
            id_pc        = rnd64();
            id_is_muldiv = 1'($urandom);
            mem_ready    = 1'($urandom);
            ex_done      = (c < base) ? 1'($urandom) : (c == e);
            ex_result    = (c == e) ? res : rnd64();
            ex_jump      = (c == e) ? jmp : 1'($urandom);
            ex_target    = (c == e) ? tgt : rnd64();
            step();
        end
        if (redir) exp_rpc = t;
        for (int c = 0; c <= bp; c++) begin
            check("out_mv", mem_valid, 1);
            check("out_en", ex_enable, 0);
            check("out_rdy", id_ready, 0);
            check("out_mres", mem_result, res);
            check("out_mpc", mem_pc, pc);
            check("out_rv", redirect_valid, (c == 0) && redir);
            check("out_mis", misalign_fault, (c == 0) && mis);
            check("out_rpc", redirect_pc, exp_rpc);
            id_valid  = 1'($urandom);
            id_pc     = rnd64();
            ex_done   = 1'($urandom);
            ex_result = rnd64();
            ex_jump   = 1'($urandom);
            ex_target = rnd64();
            mem_ready = (c == bp);
            step();
        end
        id_valid  = 1'b0;
        exp_instr = exp_instr + 32'd1;
        exp_stall = exp_stall + 32'(e - 1 + bp);
        check("post_rdy", id_ready, 1);
        check("post_mv", mem_valid, 0);
        check("post_rv", redirect_valid, 0);
        check("post_ic", instr_count, exp_instr);
        check("post_sc", stall_cycles, exp_stall);
    endtask

    initial begin
        logic [31:0] sc0;
        reset = 1'b0; id_valid = 1'b1; id_pc = 64'h1000; id_is_muldiv = 1'b0;
        ex_done = 1'b1; ex_jump = 1'b0; ex_target = '0; ex_result = '0; mem_ready = 1'b1;
        exp_instr = '0; exp_stall = '0; exp_rpc = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("rst");
        end
        reset = 1'b1;
        id_valid = 1'b0;
        step();
        check("rel_rdy", id_ready, 1);
        check("rel_ic", instr_count, 0);
        check("rel_sc", stall_cycles, 0);

        // ALU op, taken branches, misaligned jump, muldiv, backpressure
        run_instr(1'b0, 0, 0, 1'b0, 64'h0, 64'h2A, 64'h1000);
        run_instr(1'b0, 0, 0, 1'b1, 64'h1040, 64'h11, 64'h1004);
        run_instr(1'b0, 0, 0, 1'b1, 64'h2001, 64'h22, 64'h1008);
        run_instr(1'b0, 0, 0, 1'b1, 64'h2003, 64'h33, 64'h100C);
        check("mis_rpc_kept", redirect_pc, 64'h2000);
        sc0 = stall_cycles;
        run_instr(1'b1, 0, 0, 1'b0, 64'h0, 64'h44, 64'h1010);
        check("md_stall", stall_cycles - sc0, 7);
        sc0 = stall_cycles;
        run_instr(1'b0, 0, 3, 1'b0, 64'h0, 64'h55, 64'h1014);
        check("bp_stall", stall_cycles - sc0, 3);

        // Reset in the middle of a muldiv EXEC
        id_valid = 1'b1; id_pc = 64'hDEAD; id_is_muldiv = 1'b1;
        step();
        id_valid = 1'b0; ex_done = 1'b1; ex_jump = 1'b1; ex_target = 64'h3000;
        step(); step(); step();
        check("mid_en", ex_enable, 1);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        reset = 1'b1;
        exp_instr = '0; exp_stall = '0; exp_rpc = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_rdy", id_ready, 1);
            check("mr_mv", mem_valid, 0);
            check("mr_rv", redirect_valid, 0);
            check("mr_en", ex_enable, 0);
        end

        // Random instructions against the timeline model
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
            run_instr(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), rnd64(), rnd64(), rnd64());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
